mc_rq_queue: RTL and testbench
==============================

Name: mc_rq_queue

Overview:
- Request-side staging queue between the PHOLD engine's memory request port and the memory controller (MC) port.
- Absorbs MC back-pressure via a FIFO and presents an early stall upstream with a fixed slack window.
- Caps the number of outstanding reads and counts stall cycles for the stats path.
- Instantiated once per MC port; replaces the direct phold-to-MC connection.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 4.
- STALL_SLACK, 4, requests upstream may still issue after in_rq_stall first asserts; must be less than DEPTH.
- MAX_RD, 32, maximum outstanding read requests (issued reads not yet answered).
- MC_RTNCTL_WIDTH, 32, width of the rtnctl field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_rq_vld  in  1  upstream request valid; one request per cycle.
- in_rq_cmd  in  3  command: 1 = read, 2 = write, others passed through uncounted.
- in_rq_scmd  in  4  sub-command.
- in_rq_vadr  in  48  virtual address.
- in_rq_size  in  2  access size.
- in_rq_rtnctl  in  MC_RTNCTL_WIDTH  return control tag.
- in_rq_data  in  64  write data.
- in_rq_stall  out  1  back-pressure to upstream.
- mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data  out  1/3/4/48/2/MC_RTNCTL_WIDTH/64  registered request to MC.
- mc_rq_flush  out  1  tied to 0.
- mc_rq_stall  in  1  MC back-pressure.
- mc_rs_vld  in  1  MC response valid (monitored only).
- mc_rs_cmd  in  3  response type: 2 = read data, 3 = write complete.
- rd_outstanding  out  clog2(MAX_RD+1)  current outstanding read count.
- idle  out  1  FIFO empty, output register empty, rd_outstanding = 0.
- overflow  out  1  sticky: a request was dropped.
- rsp_underflow  out  1  sticky: read data arrived while rd_outstanding = 0.
- total_stalls  out  64  cycles where the queue head was blocked.

Behaviour:
- Reset values: all outputs 0, FIFO pointers and count 0, sticky flags cleared. Reset applied mid-operation discards all queued and in-flight state; no request issues on the cycle after reset.
- Push: in_rq_vld with count < DEPTH writes the request at the tail. in_rq_vld with count = DEPTH drops the request and sets overflow.
- in_rq_stall is combinational from registered state: 1 when count >= DEPTH - STALL_SLACK.
- Issue (each posedge): the head is eligible when the FIFO is non-empty, mc_rq_stall = 0, and (head cmd ≠ 1 or rd_outstanding < MAX_RD).
  - Eligible: load the head into the mc_rq_* registers, set mc_rq_vld = 1, pop the head.
  - Not eligible: mc_rq_vld = 0; the other mc_rq_* fields hold their values.
- Ordering is strictly in order. A read blocked by the MAX_RD cap also blocks any writes behind it.
- Latency: a request pushed at edge N into an empty FIFO appears on mc_rq_vld after edge N+1. Sustained throughput is 1 request per cycle.
- Simultaneous push and pop: count is unchanged, and at DEPTH this is still a drop (the push is checked against the pre-pop count).
- Pointers wrap modulo DEPTH.
- rd_outstanding:
  - +1 when a read is loaded to mc_rq.
  - -1 on mc_rs_vld with mc_rs_cmd = 2.
  - Both in the same cycle: unchanged.
  - Decrement at 0: stays 0 and sets rsp_underflow.
- total_stalls increments on every cycle where the FIFO is non-empty and the head is not eligible. It wraps at 2^64.

Test Plan:
- Single write into an empty queue, mc_rq_stall = 0 → mc_rq_vld high exactly 1 cycle, one cycle after the push; fields match; total_stalls = 0; idle returns to 1.
- 20 back-to-back writes with mc_rq_stall held at 1 → in_rq_stall asserts after the 12th push; pushes 17–20 drop and overflow = 1. Release stall → exactly 16 issues, in order, on consecutive cycles.
- MAX_RD = 32, 40 reads with no responses → exactly 32 issued, rd_outstanding = 32. Then 8 read-data responses → the remaining 8 issue and the count returns to 32.
- Read issue and read-data response in the same cycle with rd_outstanding = 5 → stays 5. A response with count 0 → stays 0 and rsp_underflow = 1.
- mc_rq_stall held 7 cycles with 3 requests queued → total_stalls = 7; after release the 3 requests issue on consecutive cycles.
- Reset asserted with 10 requests queued and rd_outstanding = 4 → the next cycle shows count 0, mc_rq_vld 0, rd_outstanding 0, in_rq_stall 0, flags cleared.

Source files
------------

// File: rtl/mc_rq_queue.sv
// mc_rq_queue: request staging FIFO between PHOLD and an MC port with early stall, read cap and stall stats
module mc_rq_queue #(
    parameter int DEPTH           = 16,
    parameter int STALL_SLACK     = 4,
    parameter int MAX_RD          = 32,
    parameter int MC_RTNCTL_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_rq_vld,
    input  logic [2:0]                 in_rq_cmd,
    input  logic [3:0]                 in_rq_scmd,
    input  logic [47:0]                in_rq_vadr,
    input  logic [1:0]                 in_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] in_rq_rtnctl,
    input  logic [63:0]                in_rq_data,
    output logic                       in_rq_stall,
    output logic                       mc_rq_vld,
    output logic [2:0]                 mc_rq_cmd,
    output logic [3:0]                 mc_rq_scmd,
    output logic [47:0]                mc_rq_vadr,
    output logic [1:0]                 mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic [63:0]                mc_rq_data,
    output logic                       mc_rq_flush,
    input  logic                       mc_rq_stall,
    input  logic                       mc_rs_vld,
    input  logic [2:0]                 mc_rs_cmd,
    output logic [$clog2(MAX_RD+1)-1:0] rd_outstanding,
    output logic                       idle,
    output logic                       overflow,
    output logic                       rsp_underflow,
    output logic [63:0]                total_stalls
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(MAX_RD + 1);

    typedef struct packed {
        logic [2:0]                 cmd;
        logic [3:0]                 scmd;
        logic [47:0]                vadr;
        logic [1:0]                 size;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [63:0]                data;
    } rq_t;

    rq_t         mem [DEPTH];
    rq_t         head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, elig, rd_inc, rd_dec;

    assign full        = count == (AW+1)'(DEPTH);
    assign empty       = count == '0;
    assign push        = in_rq_vld && !full;
    assign head        = mem[rd_ptr];
    // a read held back by the cap blocks everything behind it to keep order
    assign elig        = !empty && !mc_rq_stall && (head.cmd != 3'd1 || rd_outstanding < RW'(MAX_RD));
    assign rd_inc      = elig && head.cmd == 3'd1;
    assign rd_dec      = mc_rs_vld && mc_rs_cmd == 3'd2;
    assign in_rq_stall = count >= (AW+1)'(DEPTH - STALL_SLACK);
    assign idle        = empty && !mc_rq_vld && rd_outstanding == '0;
    assign mc_rq_flush = 1'b0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_rq_cmd, in_rq_scmd, in_rq_vadr, in_rq_size, in_rq_rtnctl, in_rq_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            mc_rq_vld      <= 1'b0;
            mc_rq_cmd      <= '0;
            mc_rq_scmd     <= '0;
            mc_rq_vadr     <= '0;
            mc_rq_size     <= '0;
            mc_rq_rtnctl   <= '0;
            mc_rq_data     <= '0;
            rd_outstanding <= '0;
            overflow       <= 1'b0;
            rsp_underflow  <= 1'b0;
            total_stalls   <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(elig);
            count     <= count + (AW+1)'(push) - (AW+1)'(elig);
            mc_rq_vld <= elig;
            if (elig) begin
                mc_rq_cmd    <= head.cmd;
                mc_rq_scmd   <= head.scmd;
                mc_rq_vadr   <= head.vadr;
                mc_rq_size   <= head.size;
                mc_rq_rtnctl <= head.rtnctl;
                mc_rq_data   <= head.data;
            end
            rd_outstanding <= (rd_inc && !rd_dec) ? rd_outstanding + RW'(1) :
                              (rd_dec && !rd_inc && rd_outstanding != '0) ? rd_outstanding - RW'(1) :
                              rd_outstanding;
            if (in_rq_vld && full) overflow <= 1'b1;
            if (rd_dec && rd_outstanding == '0) rsp_underflow <= 1'b1;
            if (!empty && !elig) total_stalls <= total_stalls + 64'd1;
        end
    end
endmodule

// File: tb/tb_mc_rq_queue.sv
// tb_mc_rq_queue: directed self-checking bench for mc_rq_queue
module tb_mc_rq_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_rq_vld;
    logic [2:0]  in_rq_cmd;
    logic [3:0]  in_rq_scmd;
    logic [47:0] in_rq_vadr;
    logic [1:0]  in_rq_size;
    logic [31:0] in_rq_rtnctl;
    logic [63:0] in_rq_data;
    logic        in_rq_stall;
    logic        mc_rq_vld;
    logic [2:0]  mc_rq_cmd;
    logic [3:0]  mc_rq_scmd;
    logic [47:0] mc_rq_vadr;
    logic [1:0]  mc_rq_size;
    logic [31:0] mc_rq_rtnctl;
    logic [63:0] mc_rq_data;
    logic        mc_rq_flush;
    logic        mc_rq_stall;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [5:0]  rd_outstanding;
    logic        idle;
    logic        overflow;
    logic        rsp_underflow;
    logic [63:0] total_stalls;

    int checks = 0;
    int errors = 0;
    int nxt;
    int issued;

    mc_rq_queue dut (
        .clk(clk), .reset(reset),
        .in_rq_vld(in_rq_vld), .in_rq_cmd(in_rq_cmd), .in_rq_scmd(in_rq_scmd),
        .in_rq_vadr(in_rq_vadr), .in_rq_size(in_rq_size), .in_rq_rtnctl(in_rq_rtnctl),
        .in_rq_data(in_rq_data), .in_rq_stall(in_rq_stall),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
        .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .rd_outstanding(rd_outstanding),
        .idle(idle), .overflow(overflow), .rsp_underflow(rsp_underflow),
        .total_stalls(total_stalls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // each issued request must carry the next expected index in its address
    task automatic track();
        tick();
        if (mc_rq_vld) begin
            chk("order", mc_rq_vadr, 48'h1000 + 48'(nxt));
            nxt++;
            issued++;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input int idx);
        in_rq_vld    = v;
        in_rq_cmd    = c;
        in_rq_scmd   = idx[3:0];
        in_rq_vadr   = 48'h1000 + 48'(idx);
        in_rq_size   = idx[1:0];
        in_rq_rtnctl = 32'(idx);
        in_rq_data   = 64'hD000_0000 + 64'(idx);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        drive(1'b0, 3'd0, 0);
        mc_rq_stall = 1'b0;
        mc_rs_vld   = 1'b0;
        mc_rs_cmd   = 3'd0;
        do_reset();
        chk("rst_vld", mc_rq_vld, 0);
        chk("rst_stall", in_rq_stall, 0);
        chk("rst_rdout", rd_outstanding, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", rsp_underflow, 0);
        chk("rst_tstall", total_stalls, 0);
        chk("rst_flush", mc_rq_flush, 0);

        // single write, one cycle latency
        drive(1'b1, 3'd2, 1);
        tick();
        drive(1'b0, 3'd0, 0);
        chk("w1_lat_vld", mc_rq_vld, 0);
        chk("w1_lat_idle", idle, 0);
        tick();
        chk("w1_vld", mc_rq_vld, 1);
        chk("w1_cmd", mc_rq_cmd, 2);
        chk("w1_scmd", mc_rq_scmd, 1);
        chk("w1_vadr", mc_rq_vadr, 48'h1001);
        chk("w1_size", mc_rq_size, 1);
        chk("w1_rtnctl", mc_rq_rtnctl, 1);
        chk("w1_data", mc_rq_data, 64'hD000_0001);
        tick();
        chk("w1_vld_off", mc_rq_vld, 0);
        chk("w1_tstall", total_stalls, 0);
        chk("w1_idle", idle, 1);
        chk("w1_hold_vadr", mc_rq_vadr, 48'h1001);

        // stall accounting: 3 queued, MC stalled
        mc_rq_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd2, 11 + i);
            tick();
        end
        drive(1'b0, 3'd0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("st_tstall", total_stalls, 7);
        mc_rq_stall = 1'b0;
        nxt = 11;
        issued = 0;
        for (int i = 0; i < 3; i++) track();
        chk("st_issued", issued, 3);
        chk("st_tstall_hold", total_stalls, 7);
        tick();
        chk("st_vld_off", mc_rq_vld, 0);

        // fill to overflow under MC stall, then drain in order
        do_reset();
        mc_rq_stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 3'd2, 100 + i);
            tick();
            if (i == 11) chk("fill_stall11", in_rq_stall, 0);
            if (i == 12) chk("fill_stall12", in_rq_stall, 1);
            if (i == 16) chk("fill_ovf16", overflow, 0);
        end
        drive(1'b0, 3'd0, 0);
        chk("fill_ovf", overflow, 1);
        chk("fill_vld", mc_rq_vld, 0);
        mc_rq_stall = 1'b0;
        nxt = 101;
        issued = 0;
        for (int i = 0; i < 16; i++) track();
        chk("drain_issued", issued, 16);
        tick();
        chk("drain_vld_off", mc_rq_vld, 0);
        chk("drain_idle", idle, 1);
        chk("drain_ovf_sticky", overflow, 1);

        // read cap: 40 reads, no responses
        do_reset();
        nxt = 200;
        issued = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 3'd1, 200 + i);
            track();
        end
        drive(1'b0, 3'd0, 0);
        for (int i = 0; i < 10; i++) track();
        chk("cap_issued", issued, 32);
        chk("cap_rdout", rd_outstanding, 32);
        chk("cap_ovf", overflow, 0);
        chk("cap_stall", in_rq_stall, 0);
        issued = 0;
        mc_rs_vld = 1'b1;
        mc_rs_cmd = 3'd2;
        for (int i = 0; i < 8; i++) track();
        mc_rs_vld = 1'b0;
        for (int i = 0; i < 5; i++) track();
        chk("cap_rest_issued", issued, 8);
        chk("cap_nxt", nxt, 240);
        chk("cap_rdout_back", rd_outstanding, 32);
        chk("cap_unf", rsp_underflow, 0);
        chk("cap_idle", idle, 0);

        // mid-operation reset with 10 queued and 4 reads outstanding
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 300 + i);
            tick();
        end
        drive(1'b0, 3'd0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("mr_rdout_pre", rd_outstanding, 4);
        mc_rq_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd2, 310 + i);
            tick();
        end
        drive(1'b0, 3'd0, 0);
        chk("mr_tstall_pre", total_stalls, 9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_vld", mc_rq_vld, 0);
        chk("mr_rdout", rd_outstanding, 0);
        chk("mr_stall", in_rq_stall, 0);
        chk("mr_tstall", total_stalls, 0);
        chk("mr_idle", idle, 1);
        mc_rq_stall = 1'b0;
        tick();
        chk("mr_no_issue1", mc_rq_vld, 0);
        tick();
        chk("mr_no_issue2", mc_rq_vld, 0);

        // outstanding counter: simultaneous inc/dec and underflow
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, 400 + i);
            tick();
        end
        drive(1'b0, 3'd0, 0);
        tick();
        tick();
        chk("rd_five", rd_outstanding, 5);
        mc_rs_vld = 1'b1;
        mc_rs_cmd = 3'd3;
        tick();
        mc_rs_vld = 1'b0;
        chk("rd_wrcomp", rd_outstanding, 5);
        drive(1'b1, 3'd1, 405);
        tick();
        drive(1'b0, 3'd0, 0);
        mc_rs_vld = 1'b1;
        mc_rs_cmd = 3'd2;
        tick();
        chk("rd_both_vld", mc_rq_vld, 1);
        chk("rd_both", rd_outstanding, 5);
        for (int i = 0; i < 5; i++) tick();
        chk("rd_zero", rd_outstanding, 0);
        chk("rd_unf_pre", rsp_underflow, 0);
        tick();
        mc_rs_vld = 1'b0;
        chk("rd_unf_cnt", rd_outstanding, 0);
        chk("rd_unf", rsp_underflow, 1);
        tick();
        chk("rd_unf_sticky", rsp_underflow, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
